// File: rtl/note_player_if.sv
// Note handshake between the song source and the note player.
// The source drives a pitch code with valid; the player answers with ready.
interface note_player_if;
    logic [3:0] note_in;
    logic       note_valid;
    logic       note_ready;

    modport master (
        output note_in,
        output note_valid,
        input  note_ready
    );

    modport slave (
        input  note_in,
        input  note_valid,
        output note_ready
    );
endinterface

// File: rtl/note_player.sv
// Note player: 4-deep pitch FIFO feeding a square-wave tone generator.
// Each slot is a tone phase followed by a silent articulation gap.
module note_player #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int NOTE_TICKS = 12_500_000,
    parameter int GAP_TICKS  = 625_000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       enable,
    note_player_if.slave src,
    output logic       audio_out,
    output logic [3:0] cur_note,
    output logic       note_start,
    output logic       playing,
    output logic [2:0] fifo_count
);

    localparam int SW = $clog2(NOTE_TICKS);
    localparam logic [SW-1:0] PLAY_LAST =
        SW'(NOTE_TICKS - GAP_TICKS - 1);
    localparam logic [SW-1:0] SLOT_LAST =
        SW'(NOTE_TICKS - 1);

    // Half period in cycles, rounded: freq given in centi-Hz.
    function automatic logic [19:0] hp_of(input longint fc);
        longint ck;
        ck = longint'(CLK_HZ) * 64'd100;
        return 20'((ck + fc) / (2 * fc));
    endfunction

    localparam logic [19:0] HP_D1  = hp_of(3671);
    localparam logic [19:0] HP_B1  = hp_of(6174);
    localparam logic [19:0] HP_DB2 = hp_of(6930);
    localparam logic [19:0] HP_D2  = hp_of(7342);
    localparam logic [19:0] HP_E2  = hp_of(8241);
    localparam logic [19:0] HP_F2  = hp_of(8731);
    localparam logic [19:0] HP_GB2 = hp_of(9250);
    localparam logic [19:0] HP_G2  = hp_of(9800);
    localparam logic [19:0] HP_A2  = hp_of(11000);
    localparam logic [19:0] HP_BB2 = hp_of(11654);
    localparam logic [19:0] HP_B2  = hp_of(12347);
    localparam logic [19:0] HP_C3  = hp_of(13081);
    localparam logic [19:0] HP_DB3 = hp_of(13859);
    localparam logic [19:0] HP_D3  = hp_of(14683);
    localparam logic [19:0] HP_E3  = hp_of(16481);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } state_t;

    state_t        state;
    state_t        state_n;
    logic          pop;
    logic          push;
    logic          empty;
    logic          full;
    logic [3:0]    mem [4];
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic [SW-1:0] slot_cnt;
    logic [19:0]   hp_cnt;
    logic [19:0]   hp;
    logic          tone;

    assign empty = (fifo_count == 3'd0);
    assign full  = (fifo_count == 3'd4);
    assign src.note_ready = ~full;
    assign push  = src.note_valid & ~full;
    assign playing = (state != IDLE);
    assign audio_out = tone & enable & (state == PLAY)
                     & (cur_note != 4'd0);

    // Pitch table lookup; REST never sounds so its entry is unused.
    always_comb begin
        hp = '0;
        unique case (cur_note)
            4'd0:  hp = '0;
            4'd1:  hp = HP_D1;
            4'd2:  hp = HP_B1;
            4'd3:  hp = HP_DB2;
            4'd4:  hp = HP_D2;
            4'd5:  hp = HP_E2;
            4'd6:  hp = HP_F2;
            4'd7:  hp = HP_GB2;
            4'd8:  hp = HP_G2;
            4'd9:  hp = HP_A2;
            4'd10: hp = HP_BB2;
            4'd11: hp = HP_B2;
            4'd12: hp = HP_C3;
            4'd13: hp = HP_DB3;
            4'd14: hp = HP_D3;
            4'd15: hp = HP_E3;
        endcase
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= src.note_in;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            fifo_count <= fifo_count + {2'b0, push} - {2'b0, pop};
        end
    end

    // State register.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // Next state and pop request; nothing advances while paused.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable && !empty) begin
                    pop     = 1'b1;
                    state_n = PLAY;
                end
            end
            PLAY: begin
                if (enable && slot_cnt == PLAY_LAST) state_n = GAP;
            end
            GAP: begin
                if (enable && slot_cnt == SLOT_LAST) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = PLAY;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Slot timing, tone generation and note loading.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            cur_note   <= '0;
            slot_cnt   <= '0;
            hp_cnt     <= '0;
            tone       <= 1'b0;
            note_start <= 1'b0;
        end else begin
            note_start <= pop;
            if (pop) begin
                cur_note <= mem[rd_ptr];
                slot_cnt <= '0;
                hp_cnt   <= '0;
                tone     <= 1'b0;
            end else if (enable && state != IDLE) begin
                slot_cnt <= slot_cnt + 1'b1;
                if (state == PLAY) begin
                    if (state_n == GAP) begin
                        tone <= 1'b0;
                    end else if (hp_cnt == hp - 20'd1) begin
                        hp_cnt <= '0;
                        tone   <= ~tone;
                    end else begin
                        hp_cnt <= hp_cnt + 20'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player with a scaled clock so that
// A2 has a 100-cycle half period and a slot is 1000 cycles.
module tb_note_player;

    localparam int HN = 6200;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       audio_out;
    logic [3:0] cur_note;
    logic       note_start;
    logic       playing;
    logic [2:0] fifo_count;

    int errors;
    int checks;
    int cyc;

    bit         aud_h [HN];
    bit         ply_h [HN];
    bit         st_h  [HN];
    logic [3:0] cn_h  [HN];

    note_player_if bus ();

    note_player #(
        .CLK_HZ     (22_000),
        .NOTE_TICKS (1000),
        .GAP_TICKS  (100)
    ) dut (
        .CLOCK_50   (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .src        (bus.slave),
        .audio_out  (audio_out),
        .cur_note   (cur_note),
        .note_start (note_start),
        .playing    (playing),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d",
                   tag, obs, exp);
        end
    endtask

    task automatic tk;
        @(negedge clk);
    endtask

    // Advance one cycle and log the outputs at index cyc.
    task automatic tickw;
        @(negedge clk);
        cyc++;
        if (cyc >= 0 && cyc < HN) begin
            aud_h[cyc] = audio_out;
            ply_h[cyc] = playing;
            st_h[cyc]  = note_start;
            cn_h[cyc]  = cur_note;
        end
    endtask

    task automatic run_to(input int last);
        while (cyc < last) tickw();
    endtask

    task automatic clr;
        for (int i = 0; i < HN; i++) begin
            aud_h[i] = 1'b0;
            ply_h[i] = 1'b0;
            st_h[i]  = 1'b0;
            cn_h[i]  = '0;
        end
    endtask

    function automatic int first_at(input int from, input bit lvl);
        for (int i = from; i < HN; i++)
            if (aud_h[i] == lvl) return i;
        return -1;
    endfunction

    function automatic int hi_count(input int a, input int b);
        int n;
        n = 0;
        for (int i = a; i <= b; i++) n += int'(aud_h[i]);
        return n;
    endfunction

    function automatic int st_count(input int a, input int b);
        int n;
        n = 0;
        for (int i = a; i <= b; i++) n += int'(st_h[i]);
        return n;
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        reset_n = 1'b0;
        enable = 1'b0;
        bus.note_in = '0;
        bus.note_valid = 1'b0;

        // Reset state
        #12;
        chk("rst_audio", audio_out, 0);
        chk("rst_playing", playing, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", bus.note_ready, 1);
        chk("rst_note", cur_note, 0);
        chk("rst_start", note_start, 0);
        tk();
        reset_n = 1'b1;
        enable = 1'b1;
        tk();

        // Single A2: push, start, tone phase, gap, idle
        clr();
        cyc = -2;
        bus.note_in = 4'd9;
        bus.note_valid = 1'b1;
        tickw();
        bus.note_valid = 1'b0;
        chk("a2_count_push", fifo_count, 1);
        chk("a2_idle_push", playing, 0);
        tickw();
        chk("a2_start", note_start, 1);
        chk("a2_note", cur_note, 9);
        chk("a2_count_pop", fifo_count, 0);
        run_to(1100);
        chk("a2_start_once", st_count(1, 1099), 0);
        chk("a2_rise", first_at(0, 1'b1), 100);
        chk("a2_fall", first_at(100, 1'b0), 200);
        chk("a2_rise2", first_at(200, 1'b1), 300);
        chk("a2_high_700", aud_h[700], 1);
        chk("a2_low_800", hi_count(800, 1099), 0);
        chk("a2_play_999", ply_h[999], 1);
        chk("a2_idle_1000", ply_h[1000], 0);

        // Back-to-back A2, REST, E3
        clr();
        cyc = -2;
        bus.note_in = 4'd9;
        bus.note_valid = 1'b1;
        tickw();
        bus.note_in = 4'd0;
        tickw();
        chk("b2b_count0", fifo_count, 1);
        bus.note_in = 4'd15;
        tickw();
        bus.note_valid = 1'b0;
        chk("b2b_count1", fifo_count, 2);
        run_to(3100);
        chk("b2b_st0", st_h[0], 1);
        chk("b2b_st1000", st_h[1000], 1);
        chk("b2b_st2000", st_h[2000], 1);
        chk("b2b_starts", st_count(0, 3099), 3);
        chk("b2b_rest_note", cn_h[1000], 0);
        chk("b2b_rest_quiet", hi_count(1000, 1999), 0);
        chk("b2b_e3_note", cn_h[2000], 15);
        chk("b2b_e3_rise", first_at(2000, 1'b1), 2067);
        chk("b2b_play_2999", ply_h[2999], 1);
        chk("b2b_idle_3000", ply_h[3000], 0);

        // Pause for 500 cycles mid-PLAY while the tone is high
        clr();
        cyc = -2;
        bus.note_in = 4'd9;
        bus.note_valid = 1'b1;
        tickw();
        bus.note_valid = 1'b0;
        run_to(150);
        chk("pz_high_before", aud_h[150], 1);
        enable = 1'b0;
        run_to(650);
        enable = 1'b1;
        run_to(1600);
        chk("pz_quiet", hi_count(151, 650), 0);
        chk("pz_playing", ply_h[400], 1);
        chk("pz_note", cn_h[400], 9);
        chk("pz_resume", aud_h[651], 1);
        chk("pz_fall_699", aud_h[699], 1);
        chk("pz_fall_700", aud_h[700], 0);
        chk("pz_play_1499", ply_h[1499], 1);
        chk("pz_idle_1500", ply_h[1500], 0);

        // FIFO full while paused, then drain with wrap and push/pop
        enable = 1'b0;
        bus.note_valid = 1'b1;
        bus.note_in = 4'd1;
        tk();
        chk("full_ready1", bus.note_ready, 1);
        bus.note_in = 4'd2;
        tk();
        bus.note_in = 4'd3;
        tk();
        chk("full_ready3", bus.note_ready, 1);
        bus.note_in = 4'd4;
        tk();
        chk("full_count4", fifo_count, 4);
        chk("full_ready0", bus.note_ready, 0);
        bus.note_in = 4'd5;
        tk();
        tk();
        tk();
        chk("full_hold_count", fifo_count, 4);
        chk("full_hold_idle", playing, 0);
        clr();
        cyc = -1;
        enable = 1'b1;
        tickw();
        chk("full_pop_count", fifo_count, 3);
        chk("full_pop_ready", bus.note_ready, 1);
        chk("full_pop_note", cur_note, 1);
        tickw();
        bus.note_valid = 1'b0;
        chk("full_5th_in", fifo_count, 4);
        run_to(2999);
        bus.note_in = 4'd6;
        bus.note_valid = 1'b1;
        tickw();
        bus.note_valid = 1'b0;
        chk("pp_count", fifo_count, 2);
        chk("pp_start", note_start, 1);
        chk("pp_note", cur_note, 4);
        run_to(6100);
        chk("ord_1000", cn_h[1000], 2);
        chk("ord_2000", cn_h[2000], 3);
        chk("ord_4000", cn_h[4000], 5);
        chk("ord_5000", cn_h[5000], 6);
        chk("ord_starts", st_count(0, 6099), 6);
        chk("ord_st5000", st_h[5000], 1);
        chk("ord_idle_6000", ply_h[6000], 0);
        chk("ord_empty", fifo_count, 0);

        // Asynchronous reset mid-note
        clr();
        cyc = -2;
        bus.note_in = 4'd9;
        bus.note_valid = 1'b1;
        tickw();
        tickw();
        bus.note_valid = 1'b0;
        run_to(150);
        chk("mid_audio_pre", audio_out, 1);
        chk("mid_count_pre", fifo_count, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_audio", audio_out, 0);
        chk("mid_playing", playing, 0);
        chk("mid_count", fifo_count, 0);
        chk("mid_ready", bus.note_ready, 1);
        chk("mid_note", cur_note, 0);
        tk();
        reset_n = 1'b1;
        tk();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/note_player.md
# note_player

Playback stage directly downstream of the song generator. It accepts 4-bit pitch codes over a valid/ready handshake and buffers them in a 4-entry FIFO. It plays each note for a fixed duration as a square wave on a single audio pin, followed by a short silent articulation gap. The song generator, or a shifter unloading its 1024-bit song register, pushes notes in; `audio_out` drives the board's audio/GPIO pin.

## Interface
- `CLK_HZ`, default 50_000_000: clock frequency used to build the pitch table.
- `NOTE_TICKS`, default 12_500_000: total cycles per note slot, tone plus gap (250 ms).
- `GAP_TICKS`, default 625_000: silent cycles at the end of each slot. Must be less than `NOTE_TICKS`.

- `CLOCK_50` in 1: system clock; all state is updated on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: 1 = play; 0 = pause.
- `note_in` in 4: pitch code. 0 REST, 1 D1, 2 B1, 3 Db2, 4 D2, 5 E2, 6 F2, 7 Gb2, 8 G2, 9 A2, 10 Bb2, 11 B2, 12 C3, 13 Db3, 14 D3, 15 E3.
- `note_valid` in 1: `note_in` is valid this cycle.
- `note_ready` out 1: FIFO can accept a note. Equals !full.
- `audio_out` out 1: square-wave output.
- `cur_note` out 4: code of the note currently sounding.
- `note_start` out 1: one-cycle pulse when a note slot begins.
- `playing` out 1: high when state is not IDLE.
- `fifo_count` out 3: number of buffered notes, 0..4.

## Operation
- FIFO
  - 4 entries, each 4 bits; 2-bit read/write pointers that wrap 3→0; 3-bit count.
  - Push when `note_valid & note_ready`. Pop is issued by the FSM.
  - Push and pop in the same cycle: both occur and the count is unchanged.
  - When full, `note_ready` is 0 even if a pop occurs in that cycle (no pass-through). A write attempted while full is dropped, and the source must hold it.
- Pitch table: combinational lookup HP[code] = round(CLK_HZ / (2·f)).
  - f is equal-tempered, with A2 = 110.00 Hz.
  - Other frequencies (Hz): D1 36.71, B1 61.74, Db2 69.30, D2 73.42, E2 82.41, F2 87.31, Gb2 92.50, G2 98.00, Bb2 116.54, B2 123.47, C3 130.81, Db3 138.59, D3 146.83, E3 164.81.
  - At 50 MHz, A2 gives HP = 227_273 and D1 gives 681_013, the maximum. The half-period counter is therefore 20 bits.
- FSM states: IDLE, PLAY, GAP.
  - IDLE: `audio_out` = 0. If `enable` and the FIFO is non-empty: pop, load `cur_note`, clear both counters, pulse `note_start`, go to PLAY.
  - PLAY: the slot counter increments each cycle.
    - The half-period counter increments and, on reaching HP[`cur_note`]−1, clears and toggles the tone register.
    - `audio_out` = tone register, or 0 if `cur_note` = REST.
    - When the slot counter reaches NOTE_TICKS−GAP_TICKS−1: go to GAP, clear the tone register.
  - GAP: `audio_out` = 0 and the slot counter keeps counting. When it reaches NOTE_TICKS−1:
    - if `enable` and the FIFO is non-empty: pop and reload exactly as in IDLE, then go to PLAY;
    - otherwise go to IDLE.
- Pause: while `enable` = 0, the slot counter, half-period counter and state freeze, and `audio_out` is forced to 0. The tone register keeps its value and resumes on re-enable. FIFO pushes are still accepted.
- Reset (asynchronous, at any time, including mid-note): state = IDLE, FIFO empty, pointers 0, `cur_note` = 0, tone register 0, counters 0. All outputs are 0 except `note_ready` = 1.

## Timing
- Accept-to-sound latency from IDLE:
  - note pushed at edge k;
  - state = PLAY, `note_start` = 1 and `cur_note` valid after edge k+1;
  - first `audio_out` rise at edge k+1+HP.
- `audio_out` is registered. The only combinational masking is the REST/GAP/pause AND.
- Back-to-back notes have no dead cycle. The next note's PLAY starts on the edge immediately after the final GAP cycle, so `note_start` pulses exactly NOTE_TICKS cycles apart.
- `note_ready` falls in the cycle after the 4th push.

## Test plan
- Reset mid-note: assert `reset_n` = 0 asynchronously while in PLAY → `audio_out`, `playing` and `fifo_count` drop to 0 immediately, and `note_ready` = 1.
- Single A2 at default parameters:
  - push code 9 → `note_start` one cycle later;
  - `audio_out` period is 454_546 cycles;
  - tone lasts 11_875_000 cycles, then 625_000 silent cycles;
  - IDLE reached after 12_500_000 cycles.
- Back-to-back with overrides NOTE_TICKS = 1000, GAP_TICKS = 100: push 9, 0, 15 → three `note_start` pulses 1000 cycles apart; `audio_out` = 0 throughout the REST slot.
- FIFO full: while the FSM is paused, push 5 notes with valid held → `note_ready` = 0 after 4 pushes and `fifo_count` = 4. The 5th note is accepted only after re-enabling causes a pop.
- Pause: drop `enable` for 500 cycles mid-PLAY → `audio_out` = 0, counters frozen; the note's total slot extends by exactly 500 cycles.
- Simultaneous push/pop: push arrives on the same edge as a GAP→PLAY pop with `fifo_count` = 2 → count stays 2, and FIFO order is preserved across pointer wrap after 6 total notes.
